// File: rtl/alu_bist_if.sv
// Signal bundle between the ALU BIST initiator and its environment: run control,
// ALU operand/function drive, ALU result return and status/signature readout.
interface alu_bist_if;
   logic        start;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [3:0]  alu_funct;
   logic [31:0] alu_result;
   logic        busy;
   logic        done;
   logic        pass;
   logic [31:0] signature;

   modport master (
      input  start, alu_result,
      output alu_op1, alu_op2, alu_funct, busy, done, pass, signature
   );

   modport slave (
      output start, alu_result,
      input  alu_op1, alu_op2, alu_funct, busy, done, pass, signature
   );
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test: drives LFSR operand pairs through all ten ALU functions,
// compacts the results into a MISR signature and compares it against a golden value.
module alu_bist #(
   parameter int unsigned NUM_PAIRS  = 16,
   parameter logic [31:0] SEED1      = 32'h0000_0001,
   parameter logic [31:0] SEED2      = 32'h0000_0002,
   parameter logic [31:0] GOLDEN_SIG = 32'h0
) (
   input  logic       clk,
   input  logic       rst,
   alu_bist_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic [3:0] {
      F_ADD, F_SUB, F_SLT, F_SLTU, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA
   } funct_e;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] SEED1_EFF = (SEED1 == 32'h0) ? 32'h1 : SEED1;
   localparam logic [31:0] SEED2_EFF = (SEED2 == 32'h0) ? 32'h1 : SEED2;
   localparam logic [31:0] LAST_PAIR = 32'(NUM_PAIRS - 1);

   state_e      state_q, state_d;
   funct_e      funct_q, funct_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [31:0] pair_q, pair_d;
   logic [31:0] sig_q, sig_d;
   logic        pass_q, pass_d;
   logic [31:0] misr_next;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : '0);
   endfunction

   // The operand registers double as the LFSRs and are zeroed outside RUN,
   // so the ALU outputs stay registered and idle at 0/0/ADD.
   always_comb begin
      state_d   = state_q;
      funct_d   = funct_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      pair_d    = pair_q;
      sig_d     = sig_q;
      pass_d    = pass_q;
      misr_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : '0) ^ bus.alu_result;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               funct_d = F_ADD;
               op1_d   = SEED1_EFF;
               op2_d   = SEED2_EFF;
               pair_d  = '0;
               sig_d   = '0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            sig_d = misr_next;
            if (funct_q == F_SRA) begin
               funct_d = F_ADD;
               if (pair_q == LAST_PAIR) begin
                  state_d = DONE;
                  op1_d   = '0;
                  op2_d   = '0;
                  pass_d  = (misr_next == GOLDEN_SIG);
               end else begin
                  op1_d  = lfsr_step(op1_q);
                  op2_d  = lfsr_step(op2_q);
                  pair_d = pair_q + 32'd1;
               end
            end else begin
               funct_d = funct_e'(funct_q + 4'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         funct_q <= F_ADD;
         op1_q   <= '0;
         op2_q   <= '0;
         pair_q  <= '0;
         sig_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         funct_q <= funct_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         pair_q  <= pair_d;
         sig_q   <= sig_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.alu_op1   = op1_q;
   assign bus.alu_op2   = op2_q;
   assign bus.alu_funct = funct_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = pass_q;
   assign bus.signature = sig_q;

endmodule
